// File: rtl/trace_checker_if.sv
// Retire-event and golden-trace read bundle for trace_checker.
// slave = checker side, master = CPU/trace-memory side.
interface trace_checker_if #(
    parameter int unsigned IDX_W = 10
);
    logic             retire_valid;
    logic [31:0]      retire_pc;
    logic [31:0]      retire_instr;
    logic [4:0]       retire_rd;
    logic             retire_rd_we;
    logic [31:0]      retire_rd_data;
    logic             retire_mem_we;
    logic [31:0]      retire_mem_addr;
    logic [31:0]      retire_mem_wdata;

    logic             gold_req;
    logic [IDX_W-1:0] gold_index;
    logic             gold_ack;
    logic [31:0]      gold_pc;
    logic [31:0]      gold_instr;
    logic [4:0]       gold_rd;
    logic             gold_rd_we;
    logic [31:0]      gold_rd_data;
    logic             gold_mem_we;
    logic [31:0]      gold_mem_addr;
    logic [31:0]      gold_mem_wdata;
    logic             gold_last;

    modport slave (
        input  retire_valid, retire_pc, retire_instr, retire_rd, retire_rd_we, retire_rd_data,
        input  retire_mem_we, retire_mem_addr, retire_mem_wdata,
        input  gold_ack, gold_pc, gold_instr, gold_rd, gold_rd_we, gold_rd_data,
        input  gold_mem_we, gold_mem_addr, gold_mem_wdata, gold_last,
        output gold_req, gold_index
    );

    modport master (
        output retire_valid, retire_pc, retire_instr, retire_rd, retire_rd_we, retire_rd_data,
        output retire_mem_we, retire_mem_addr, retire_mem_wdata,
        output gold_ack, gold_pc, gold_instr, gold_rd, gold_rd_we, gold_rd_data,
        output gold_mem_we, gold_mem_addr, gold_mem_wdata, gold_last,
        input  gold_req, gold_index
    );
endinterface

// File: rtl/trace_checker.sv
// Lock-step checker: compares live CPU retire events against a golden trace record by record.
// Define TRACE_CHECKER_MEM_CHECK_EN to also compare store fields (fail code 5).
module trace_checker #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    trace_checker_if.slave   tif,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [IDX_W-1:0] fail_index,
    output logic [2:0]       fail_field,
    output logic [IDX_W:0]   checked_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [IDX_W-1:0] IDX_MAX    = {IDX_W{1'b1}};
    localparam logic [2:0]       CODE_NONE  = 3'd0;
    localparam logic [2:0]       CODE_PC    = 3'd1;
    localparam logic [2:0]       CODE_INSTR = 3'd2;
    localparam logic [2:0]       CODE_RD    = 3'd3;
    localparam logic [2:0]       CODE_DATA  = 3'd4;
`ifdef TRACE_CHECKER_MEM_CHECK_EN
    localparam logic [2:0]       CODE_MEM   = 3'd5;
`endif
    localparam logic [2:0]       CODE_LIMIT = 3'd6;
    localparam logic [2:0]       CODE_OVF   = 3'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rd_data;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } rec_t;

    typedef enum logic [2:0] {IDLE, REQ, COMPARE, PASS, FAIL} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   cnt_d;
    logic [IDX_W-1:0] fail_index_d;
    logic [2:0]       fail_field_d;
    logic             gold_req_q;
    logic             latch_gold, push, pop, flush, fifo_we;
    logic [2:0]       mis_code;

    rec_t             retire_rec, gold_in, gold_q, head;
    logic             gold_last_q;

    rec_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty, fifo_full;

    assign retire_rec = '{pc: tif.retire_pc, instr: tif.retire_instr, rd: tif.retire_rd,
                          rd_we: tif.retire_rd_we, rd_data: tif.retire_rd_data,
                          mem_we: tif.retire_mem_we, mem_addr: tif.retire_mem_addr,
                          mem_wdata: tif.retire_mem_wdata};
    assign gold_in    = '{pc: tif.gold_pc, instr: tif.gold_instr, rd: tif.gold_rd,
                          rd_we: tif.gold_rd_we, rd_data: tif.gold_rd_data,
                          mem_we: tif.gold_mem_we, mem_addr: tif.gold_mem_addr,
                          mem_wdata: tif.gold_mem_wdata};

    assign tif.gold_req   = gold_req_q;
    assign tif.gold_index = idx_q;

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_we    = push && (!fifo_full || pop);

    // First mismatching field wins; code 0 means the FIFO head matches the latched record.
    always_comb begin
        mis_code = CODE_NONE;
        if (head.pc != gold_q.pc) begin
            mis_code = CODE_PC;
        end else if (head.instr != gold_q.instr) begin
            mis_code = CODE_INSTR;
        end else if ((head.rd_we != gold_q.rd_we) || (gold_q.rd_we && (head.rd != gold_q.rd))) begin
            mis_code = CODE_RD;
        end else if (gold_q.rd_we && (gold_q.rd != 5'd0) && (head.rd_data != gold_q.rd_data)) begin
            mis_code = CODE_DATA;
`ifdef TRACE_CHECKER_MEM_CHECK_EN
        end else if ((head.mem_we != gold_q.mem_we) ||
                     (gold_q.mem_we && ((head.mem_addr != gold_q.mem_addr) ||
                                        (head.mem_wdata != gold_q.mem_wdata)))) begin
            mis_code = CODE_MEM;
`endif
        end
    end

`ifndef TRACE_CHECKER_MEM_CHECK_EN
    logic unused_mem;
    assign unused_mem = ^{head.mem_we, head.mem_addr, head.mem_wdata,
                          gold_q.mem_we, gold_q.mem_addr, gold_q.mem_wdata};
`endif

    // Next-state, index/count and failure-report logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = checked_count;
        fail_index_d = fail_index;
        fail_field_d = fail_field;
        latch_gold   = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        if (start) begin
            state_d      = REQ;
            idx_d        = '0;
            cnt_d        = '0;
            fail_index_d = '0;
            fail_field_d = CODE_NONE;
            flush        = 1'b1;
        end else begin
            push = tif.retire_valid && ((state_q == REQ) || (state_q == COMPARE));
            case (state_q)
                REQ: begin
                    if (tif.gold_ack) begin
                        latch_gold = 1'b1;
                        state_d    = COMPARE;
                    end
                end
                COMPARE: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (mis_code != CODE_NONE) begin
                            state_d      = FAIL;
                            fail_field_d = mis_code;
                            fail_index_d = idx_q;
                        end else begin
                            cnt_d = checked_count + 1'b1;
                            if (gold_last_q) begin
                                state_d = PASS;
                            end else if (idx_q == IDX_MAX) begin
                                state_d      = FAIL;
                                fail_field_d = CODE_LIMIT;
                                fail_index_d = idx_q;
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = REQ;
                            end
                        end
                    end
                end
                default: ;
            endcase
            // Overflow only when full with no pop freeing a slot in the same cycle.
            if (push && fifo_full && !pop) begin
                state_d      = FAIL;
                fail_field_d = CODE_OVF;
                fail_index_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            gold_req_q    <= 1'b0;
            busy          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            fail_index    <= '0;
            fail_field    <= CODE_NONE;
            checked_count <= '0;
            gold_q        <= '0;
            gold_last_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gold_req_q    <= (state_d == REQ);
            busy          <= (state_d == REQ) || (state_d == COMPARE);
            pass          <= (state_d == PASS);
            fail          <= (state_d == FAIL);
            fail_index    <= fail_index_d;
            fail_field    <= fail_field_d;
            checked_count <= cnt_d;
            if (latch_gold) begin
                gold_q      <= gold_in;
                gold_last_q <= tif.gold_last;
            end
        end
    end

    // Observed-retire FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_we) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_we, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_we) fifo_mem[wr_ptr] <= retire_rec;
    end
endmodule

// File: tb/tb_trace_checker.sv
// Directed self-checking bench for trace_checker (IDX_W=10 main instance, IDX_W=2 index-limit instance).
`timescale 1ns/1ps
module tb_trace_checker;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rd_data;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start2;
    logic busy, pass, fail;
    logic [9:0]  fail_index;
    logic [2:0]  fail_field;
    logic [10:0] checked_count;
    logic busy2, pass2, fail2;
    logic [1:0]  fail_index2;
    logic [2:0]  fail_field2;
    logic [2:0]  checked_count2;

    int checks   = 0;
    int failures = 0;

    rec_t gmem [16];
    logic glast [16];
    rec_t rets [16];

    trace_checker_if #(.IDX_W(10)) tif ();
    trace_checker_if #(.IDX_W(2))  tif2 ();

    trace_checker #(.FIFO_DEPTH(4), .IDX_W(10)) dut (
        .clk(clk), .reset(rst), .start(start), .tif(tif),
        .busy(busy), .pass(pass), .fail(fail), .fail_index(fail_index),
        .fail_field(fail_field), .checked_count(checked_count)
    );

    trace_checker #(.FIFO_DEPTH(4), .IDX_W(2)) dut2 (
        .clk(clk), .reset(rst), .start(start2), .tif(tif2),
        .busy(busy2), .pass(pass2), .fail(fail2), .fail_index(fail_index2),
        .fail_field(fail_field2), .checked_count(checked_count2)
    );

    // Golden-trace responders: ack `lat` cycles after gold_req is first seen.
    int   lat = 0;
    int   wcnt = 0;
    logic r_ack = 1'b0, m_ack = 1'b0, r_last = 1'b0;
    rec_t r_rec = '0;
    logic r2_ack = 1'b0, r2_last = 1'b0;
    rec_t r2_rec = '0;

    always @(negedge clk) begin
        if (tif.gold_req && !rst) begin
            if (wcnt >= lat) begin
                r_ack  <= 1'b1;
                r_rec  <= gmem[tif.gold_index[3:0]];
                r_last <= glast[tif.gold_index[3:0]];
                wcnt   <= 0;
            end else begin
                r_ack <= 1'b0;
                wcnt  <= wcnt + 1;
            end
        end else begin
            r_ack <= 1'b0;
            wcnt  <= 0;
        end
    end

    always @(negedge clk) begin
        r2_ack  <= tif2.gold_req && !rst;
        r2_rec  <= gmem[{2'b00, tif2.gold_index}];
        r2_last <= glast[{2'b00, tif2.gold_index}];
    end

    assign tif.gold_ack       = r_ack | m_ack;
    assign tif.gold_pc        = r_rec.pc;
    assign tif.gold_instr     = r_rec.instr;
    assign tif.gold_rd        = r_rec.rd;
    assign tif.gold_rd_we     = r_rec.rd_we;
    assign tif.gold_rd_data   = r_rec.rd_data;
    assign tif.gold_mem_we    = r_rec.mem_we;
    assign tif.gold_mem_addr  = r_rec.mem_addr;
    assign tif.gold_mem_wdata = r_rec.mem_wdata;
    assign tif.gold_last      = r_last;

    assign tif2.gold_ack       = r2_ack;
    assign tif2.gold_pc        = r2_rec.pc;
    assign tif2.gold_instr     = r2_rec.instr;
    assign tif2.gold_rd        = r2_rec.rd;
    assign tif2.gold_rd_we     = r2_rec.rd_we;
    assign tif2.gold_rd_data   = r2_rec.rd_data;
    assign tif2.gold_mem_we    = r2_rec.mem_we;
    assign tif2.gold_mem_addr  = r2_rec.mem_addr;
    assign tif2.gold_mem_wdata = r2_rec.mem_wdata;
    assign tif2.gold_last      = r2_last;

    function automatic rec_t mk(input int i);
        rec_t r;
        r.pc        = 32'h0000_1000 + 32'(i * 4);
        r.instr     = 32'h0000_0013 + 32'(i << 7);
        r.rd        = 5'(i + 1);
        r.rd_we     = 1'b1;
        r.rd_data   = 32'h0000_0100 + 32'(i);
        r.mem_we    = 1'b0;
        r.mem_addr  = 32'h0;
        r.mem_wdata = 32'h0;
        return r;
    endfunction

    task automatic load_trace(input int n);
        for (int i = 0; i < 16; i++) begin
            gmem[i]  = mk(i);
            rets[i]  = mk(i);
            glast[i] = (i == n - 1);
        end
    endtask

    task automatic drive_retire(input rec_t r, input logic v);
        tif.retire_valid     = v;
        tif.retire_pc        = r.pc;
        tif.retire_instr     = r.instr;
        tif.retire_rd        = r.rd;
        tif.retire_rd_we     = r.rd_we;
        tif.retire_rd_data   = r.rd_data;
        tif.retire_mem_we    = r.mem_we;
        tif.retire_mem_addr  = r.mem_addr;
        tif.retire_mem_wdata = r.mem_wdata;
    endtask

    task automatic drive_retire2(input rec_t r, input logic v);
        tif2.retire_valid     = v;
        tif2.retire_pc        = r.pc;
        tif2.retire_instr     = r.instr;
        tif2.retire_rd        = r.rd;
        tif2.retire_rd_we     = r.rd_we;
        tif2.retire_rd_data   = r.rd_data;
        tif2.retire_mem_we    = r.mem_we;
        tif2.retire_mem_addr  = r.mem_addr;
        tif2.retire_mem_wdata = r.mem_wdata;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_retires(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) drive_retire(rets[i], 1'b1);
        end
        @(negedge clk) drive_retire(rets[0], 1'b0);
    endtask

    task automatic wait_done(input bit second, input int budget);
        int n;
        n = 0;
        while (!(second ? (pass2 || fail2) : (pass || fail)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(second ? (pass2 || fail2) : (pass || fail))) begin
            failures++;
            $display("FAIL done_timeout: no pass/fail after %0d cycles (inst2=%0b)", n, second);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, pass, fail, tif.gold_req} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got busy/pass/fail/req=%b want 0000", {busy, pass, fail, tif.gold_req});
        end
        checks++;
        if ({fail_index, fail_field, checked_count, tif.gold_index} !== '0) begin
            failures++;
            $display("FAIL reset_values: got fi=%0d ff=%0d cnt=%0d gidx=%0d want all 0",
                     fail_index, fail_field, checked_count, tif.gold_index);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_start();
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, tif.gold_req} !== 2'b00) begin
            failures++;
            $display("FAIL reset_over_start: got busy/req=%b want 00", {busy, tif.gold_req});
        end
    endtask

    task automatic test_pass();
        load_trace(3);
        lat = 2;
        pulse_start();
        checks++;
        if ({busy, tif.gold_req} !== 2'b11) begin
            failures++;
            $display("FAIL run_busy: got busy/req=%b want 11", {busy, tif.gold_req});
        end
        send_retires(3);
        wait_done(1'b0, 200);
        checks++;
        if ({pass, fail, busy} !== 3'b100) begin
            failures++;
            $display("FAIL pass_flags: got pass/fail/busy=%b want 100", {pass, fail, busy});
        end
        checks++;
        if (checked_count !== 11'd3) begin
            failures++;
            $display("FAIL pass_count: got %0d want 3", checked_count);
        end
    endtask

    task automatic test_rd_data();
        load_trace(3);
        lat = 1;
        gmem[1].rd_data = 32'h0000_0005;
        rets[1].rd_data = 32'h0000_0006;
        pulse_start();
        send_retires(3);
        wait_done(1'b0, 200);
        checks++;
        if ({pass, fail, fail_field, fail_index, checked_count} !== {1'b0, 1'b1, 3'd4, 10'd1, 11'd1}) begin
            failures++;
            $display("FAIL rd_data: got pass=%0b fail=%0b ff=%0d fi=%0d cnt=%0d want 0 1 4 1 1",
                     pass, fail, fail_field, fail_index, checked_count);
        end
    endtask

    task automatic test_field_codes();
        int exp_ff [6] = '{1, 2, 3, 3, 0, 0};
        for (int k = 0; k < 6; k++) begin
            load_trace(2);
            lat = 0;
            case (k)
                0: begin rets[1].pc ^= 32'h4; rets[1].rd_data ^= 32'h1; end
                1: begin rets[1].instr ^= 32'h1; rets[1].rd_data ^= 32'h1; end
                2: begin rets[1].rd = 5'd9; rets[1].rd_data ^= 32'h1; end
                3: rets[1].rd_we = 1'b0;
                4: begin gmem[1].rd = 5'd0; rets[1].rd = 5'd0; rets[1].rd_data = 32'hDEAD; end
                default: begin gmem[1].rd_we = 1'b0; rets[1].rd_we = 1'b0; rets[1].rd = 5'd7; end
            endcase
            pulse_start();
            send_retires(2);
            wait_done(1'b0, 200);
            checks++;
            if (exp_ff[k] != 0) begin
                if ({fail, pass, fail_field, fail_index, checked_count} !==
                    {1'b1, 1'b0, 3'(exp_ff[k]), 10'd1, 11'd1}) begin
                    failures++;
                    $display("FAIL field_case%0d: got fail=%0b pass=%0b ff=%0d fi=%0d cnt=%0d want 1 0 %0d 1 1",
                             k, fail, pass, fail_field, fail_index, checked_count, exp_ff[k]);
                end
            end else if ({pass, fail, fail_field, fail_index, checked_count} !==
                         {1'b1, 1'b0, 3'd0, 10'd0, 11'd2}) begin
                failures++;
                $display("FAIL field_case%0d: got pass=%0b fail=%0b ff=%0d fi=%0d cnt=%0d want 1 0 0 0 2",
                         k, pass, fail, fail_field, fail_index, checked_count);
            end
        end
    endtask

    task automatic test_overflow();
        load_trace(8);
        lat = 20;
        pulse_start();
        send_retires(5);
        checks++;
        if ({fail, pass, busy, fail_field, fail_index, checked_count} !==
            {1'b1, 1'b0, 1'b0, 3'd7, 10'd0, 11'd0}) begin
            failures++;
            $display("FAIL overflow: got fail=%0b pass=%0b busy=%0b ff=%0d fi=%0d cnt=%0d want 1 0 0 7 0 0",
                     fail, pass, busy, fail_field, fail_index, checked_count);
        end
    endtask

    task automatic test_mem();
        load_trace(1);
        lat = 1;
        gmem[0].mem_we    = 1'b1;
        gmem[0].mem_addr  = 32'h0000_0104;
        gmem[0].mem_wdata = 32'h0000_00AB;
        rets[0].mem_we    = 1'b1;
        rets[0].mem_addr  = 32'h0000_0100;
        rets[0].mem_wdata = 32'h0000_00AB;
        pulse_start();
        send_retires(1);
        wait_done(1'b0, 200);
        checks++;
`ifdef TRACE_CHECKER_MEM_CHECK_EN
        if ({fail, pass, fail_field, fail_index} !== {1'b1, 1'b0, 3'd5, 10'd0}) begin
            failures++;
            $display("FAIL mem_store: got fail=%0b pass=%0b ff=%0d fi=%0d want 1 0 5 0",
                     fail, pass, fail_field, fail_index);
        end
`else
        if ({pass, fail, fail_field, checked_count} !== {1'b1, 1'b0, 3'd0, 11'd1}) begin
            failures++;
            $display("FAIL mem_store: got pass=%0b fail=%0b ff=%0d cnt=%0d want 1 0 0 1",
                     pass, fail, fail_field, checked_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        load_trace(3);
        lat = 50;
        pulse_start();
        repeat (3) @(negedge clk);
        checks++;
        if (tif.gold_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_req_high: got %0b want 1", tif.gold_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tif.gold_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_req_drop: got %0b want 0", tif.gold_req);
        end
        @(negedge clk) rst = 1'b0;
        m_ack = 1'b1;
        @(negedge clk) m_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, pass, fail, tif.gold_req, fail_field, fail_index, checked_count, tif.gold_index} !== '0) begin
            failures++;
            $display("FAIL late_ack: got busy=%0b pass=%0b fail=%0b req=%0b ff=%0d fi=%0d cnt=%0d gidx=%0d want all 0",
                     busy, pass, fail, tif.gold_req, fail_field, fail_index, checked_count, tif.gold_index);
        end
        lat = 1;
        pulse_start();
        send_retires(3);
        wait_done(1'b0, 200);
        checks++;
        if ({pass, fail, checked_count} !== {1'b1, 1'b0, 11'd3}) begin
            failures++;
            $display("FAIL after_reset_run: got pass=%0b fail=%0b cnt=%0d want 1 0 3", pass, fail, checked_count);
        end
    endtask

    task automatic test_back_to_back();
        load_trace(3);
        lat = 1;
        rets[1].pc = 32'hBAD0_0000;
        pulse_start();
        send_retires(1);
        repeat (3) @(negedge clk);
        pulse_start();
        checks++;
        if ({busy, pass, fail, checked_count} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
            failures++;
            $display("FAIL restart_clear: got busy=%0b pass=%0b fail=%0b cnt=%0d want 1 0 0 0",
                     busy, pass, fail, checked_count);
        end
        rets[1] = mk(1);
        send_retires(3);
        wait_done(1'b0, 200);
        checks++;
        if ({pass, fail, checked_count} !== {1'b1, 1'b0, 11'd3}) begin
            failures++;
            $display("FAIL restart_pass: got pass=%0b fail=%0b cnt=%0d want 1 0 3", pass, fail, checked_count);
        end
    endtask

    task automatic test_index_limit();
        load_trace(4);
        for (int i = 0; i < 16; i++) glast[i] = 1'b0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) drive_retire2(rets[i], 1'b1);
        end
        @(negedge clk) drive_retire2(rets[0], 1'b0);
        wait_done(1'b1, 200);
        checks++;
        if ({fail2, pass2, fail_field2, fail_index2} !== {1'b1, 1'b0, 3'd6, 2'd3}) begin
            failures++;
            $display("FAIL index_limit: got fail=%0b pass=%0b ff=%0d fi=%0d want 1 0 6 3",
                     fail2, pass2, fail_field2, fail_index2);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        drive_retire('0, 1'b0);
        drive_retire2('0, 1'b0);
        load_trace(1);
        test_reset();
        test_reset_start();
        test_pass();
        test_rd_data();
        test_field_codes();
        test_overflow();
        test_mem();
        test_reset_mid();
        test_back_to_back();
        test_index_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
